// File: rtl/cpu_pkg.sv
// Shared constants for the five-stage MIPS core: reset/handler PCs, ExcCodes, field widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    // Default field widths used by the inter-stage registers
    localparam int TNEW_W_DEF = 4;
    localparam int EXC_W_DEF  = 5;

    // Architectural PCs: first fetch after reset, and the CP0 exception entry point
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    // CP0 ExcCode values
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

endpackage

// File: rtl/sat_dec.sv
// Saturating decrement by one: 0 stays 0, anything else drops by one.
// Latency: combinational.
// Backpressure: n/a.
module sat_dec #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    // Clamp at zero so a Tnew countdown never wraps to the maximum value
    assign o_val = (i_val == '0) ? '0 : (i_val - W'(1));

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W) with stall, bubble, redirect and Tnew countdown.
// Latency: one cycle from inputs to outputs on advance; outputs come straight from flops.
// Backpressure: en=0 holds the slot (optionally counting Tnew down); flush bubbles; req redirects.
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int          DATA_W     = 128,
    parameter int          TNEW_W     = TNEW_W_DEF,
    parameter int          EXC_W      = EXC_W_DEF,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter bit          TNEW_DEC   = 1'b1,
    parameter bit          HOLD_DEC   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              en,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic              in_bd,
    input  logic              in_exc_vld,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              local_exc_vld,
    input  logic [EXC_W-1:0]  local_exc,
    input  logic              in_grf_write,
    input  logic [4:0]        in_a3,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [DATA_W-1:0] in_payload,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              out_bd,
    output logic              out_exc_vld,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_grf_write,
    output logic [4:0]        out_a3,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [DATA_W-1:0] out_payload
);

    // Slot state
    logic              r_valid;
    logic [31:0]       r_pc;
    logic [31:0]       r_instr;
    logic              r_bd;
    logic              r_exc_vld;
    logic [EXC_W-1:0]  r_exc;
    logic              r_grf_write;
    logic [4:0]        r_a3;
    logic [TNEW_W-1:0] r_tnew;
    logic [DATA_W-1:0] r_payload;

    // Advance-path derived values
    logic              w_exc_any;
    logic [EXC_W-1:0]  w_exc_code;
    logic              w_grf_write;
    logic [TNEW_W-1:0] w_in_tnew_dec;
    logic [TNEW_W-1:0] w_adv_tnew;

    // Hold-path derived values
    logic [TNEW_W-1:0] w_r_tnew_dec;
    logic [TNEW_W-1:0] w_hold_tnew;

    // The older (upstream) exception takes precedence over one raised in this stage,
    // and any faulting instruction has its register write suppressed.
    assign w_exc_any   = in_exc_vld | local_exc_vld;
    assign w_exc_code  = in_exc_vld ? in_exc : local_exc;
    assign w_grf_write = in_grf_write & ~w_exc_any;

    // Tnew countdown as the instruction moves one stage forward
    sat_dec #(.W(TNEW_W)) u_adv_dec (
        .i_val (in_tnew),
        .o_val (w_in_tnew_dec)
    );
    assign w_adv_tnew = TNEW_DEC ? w_in_tnew_dec : in_tnew;

    // Tnew countdown while a multi-cycle unit keeps the instruction parked here
    sat_dec #(.W(TNEW_W)) u_hold_dec (
        .i_val (r_tnew),
        .o_val (w_r_tnew_dec)
    );
    assign w_hold_tnew = HOLD_DEC ? w_r_tnew_dec : r_tnew;

    // Slot update with priority reset > req > flush > en > hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_bd        <= 1'b0;
            r_exc_vld   <= 1'b0;
            r_exc       <= '0;
            r_grf_write <= 1'b0;
            r_a3        <= '0;
            r_tnew      <= '0;
            r_payload   <= '0;
        end else if (req) begin
            // Redirect to the handler; whatever was entering is discarded
            r_valid     <= 1'b0;
            r_pc        <= HANDLER_PC;
            r_instr     <= '0;
            r_bd        <= 1'b0;
            r_exc_vld   <= 1'b0;
            r_exc       <= '0;
            r_grf_write <= 1'b0;
            r_a3        <= '0;
            r_tnew      <= '0;
            r_payload   <= '0;
        end else if (flush) begin
            // Bubble keeps PC and BD so CP0 can still report a correct EPC/BD
            r_valid     <= 1'b0;
            r_pc        <= in_pc;
            r_instr     <= '0;
            r_bd        <= in_bd;
            r_exc_vld   <= 1'b0;
            r_exc       <= '0;
            r_grf_write <= 1'b0;
            r_a3        <= '0;
            r_tnew      <= '0;
            r_payload   <= '0;
        end else if (en) begin
            r_valid     <= 1'b1;
            r_pc        <= in_pc;
            r_instr     <= in_instr;
            r_bd        <= in_bd;
            r_exc_vld   <= w_exc_any;
            r_exc       <= w_exc_code;
            r_grf_write <= w_grf_write;
            r_a3        <= in_a3;
            r_tnew      <= w_adv_tnew;
            r_payload   <= in_payload;
        end else begin
            // Stall: everything held, Tnew optionally counts down
            r_tnew      <= w_hold_tnew;
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign out_instr     = r_instr;
    assign out_bd        = r_bd;
    assign out_exc_vld   = r_exc_vld;
    assign out_exc       = r_exc;
    assign out_grf_write = r_grf_write;
    assign out_a3        = r_a3;
    assign out_tnew      = r_tnew;
    assign out_payload   = r_payload;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one instance with HOLD_DEC=1 and one with HOLD_DEC=0 share stimulus.
// Expected slot contents are queued as stimulus is applied and compared after the clock edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic         valid;
        logic [31:0]  pc;
        logic [31:0]  instr;
        logic         bd;
        logic         exc_vld;
        logic [4:0]   exc;
        logic         grf_write;
        logic [4:0]   a3;
        logic [3:0]   tnew;
        logic [127:0] payload;
    } obs_t;

    logic         clk;
    logic         reset;
    logic         req;
    logic         flush;
    logic         en;
    logic [31:0]  in_pc;
    logic [31:0]  in_instr;
    logic         in_bd;
    logic         in_exc_vld;
    logic [4:0]   in_exc;
    logic         local_exc_vld;
    logic [4:0]   local_exc;
    logic         in_grf_write;
    logic [4:0]   in_a3;
    logic [3:0]   in_tnew;
    logic [127:0] in_payload;

    logic         o1_valid, o1_bd, o1_exc_vld, o1_grf_write;
    logic [31:0]  o1_pc, o1_instr;
    logic [4:0]   o1_exc, o1_a3;
    logic [3:0]   o1_tnew;
    logic [127:0] o1_payload;

    logic         o2_valid, o2_bd, o2_exc_vld, o2_grf_write;
    logic [31:0]  o2_pc, o2_instr;
    logic [4:0]   o2_exc, o2_a3;
    logic [3:0]   o2_tnew;
    logic [127:0] o2_payload;

    obs_t obs1;
    obs_t obs2;
    assign obs1 = {o1_valid, o1_pc, o1_instr, o1_bd, o1_exc_vld, o1_exc, o1_grf_write, o1_a3, o1_tnew, o1_payload};
    assign obs2 = {o2_valid, o2_pc, o2_instr, o2_bd, o2_exc_vld, o2_exc, o2_grf_write, o2_a3, o2_tnew, o2_payload};

    obs_t sb1_q[$];
    obs_t sb2_q[$];
    obs_t cur_exp;
    obs_t rst_exp;
    obs_t e;
    int   n_pass;
    int   n_total;

    pipe_stage_reg #(.HOLD_DEC(1'b1)) u_dut (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .en(en),
        .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd),
        .in_exc_vld(in_exc_vld), .in_exc(in_exc),
        .local_exc_vld(local_exc_vld), .local_exc(local_exc),
        .in_grf_write(in_grf_write), .in_a3(in_a3), .in_tnew(in_tnew), .in_payload(in_payload),
        .out_valid(o1_valid), .out_pc(o1_pc), .out_instr(o1_instr), .out_bd(o1_bd),
        .out_exc_vld(o1_exc_vld), .out_exc(o1_exc), .out_grf_write(o1_grf_write),
        .out_a3(o1_a3), .out_tnew(o1_tnew), .out_payload(o1_payload)
    );

    pipe_stage_reg #(.HOLD_DEC(1'b0)) u_dut_nh (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .en(en),
        .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd),
        .in_exc_vld(in_exc_vld), .in_exc(in_exc),
        .local_exc_vld(local_exc_vld), .local_exc(local_exc),
        .in_grf_write(in_grf_write), .in_a3(in_a3), .in_tnew(in_tnew), .in_payload(in_payload),
        .out_valid(o2_valid), .out_pc(o2_pc), .out_instr(o2_instr), .out_bd(o2_bd),
        .out_exc_vld(o2_exc_vld), .out_exc(o2_exc), .out_grf_write(o2_grf_write),
        .out_a3(o2_a3), .out_tnew(o2_tnew), .out_payload(o2_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        req = 0; flush = 0; en = 0;
        in_pc = 32'h0; in_instr = 32'h0; in_bd = 0;
        in_exc_vld = 0; in_exc = 5'd0; local_exc_vld = 0; local_exc = 5'd0;
        in_grf_write = 0; in_a3 = 5'd0; in_tnew = 4'd0; in_payload = '0;
    endtask

    // Reference behaviour of the HOLD_DEC=1, TNEW_DEC=1 instance from the current inputs
    function automatic obs_t model(obs_t cur);
        obs_t n;
        n = cur;
        if (req) begin
            n = '0;
            n.pc = 32'h0000_4180;
        end else if (flush) begin
            n = '0;
            n.pc = in_pc;
            n.bd = in_bd;
        end else if (en) begin
            n.valid     = 1'b1;
            n.pc        = in_pc;
            n.instr     = in_instr;
            n.bd        = in_bd;
            n.exc_vld   = in_exc_vld | local_exc_vld;
            n.exc       = in_exc_vld ? in_exc : local_exc;
            n.grf_write = in_grf_write & ~(in_exc_vld | local_exc_vld);
            n.a3        = in_a3;
            n.tnew      = (in_tnew == 4'd0) ? 4'd0 : in_tnew - 4'd1;
            n.payload   = in_payload;
        end else begin
            n.tnew = (cur.tnew == 4'd0) ? 4'd0 : cur.tnew - 4'd1;
        end
        return n;
    endfunction

    task automatic test_reset;
        obs_t x;
        // Held in reset from time zero with en=1
        en = 1; in_pc = 32'h3010; in_tnew = 4'd5; in_grf_write = 1;
        sb1_q.push_back(rst_exp); sb2_q.push_back(rst_exp);
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL reset_hold1: got %h exp %h", obs1, x); else n_pass++;
        x = sb2_q.pop_front(); n_total++;
        if (obs2 !== x) $display("FAIL reset_hold2: got %h exp %h", obs2, x); else n_pass++;
        // Release during a stall: contents stay at the reset values
        reset = 0; drive_idle();
        sb1_q.push_back(rst_exp);
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL reset_release_stall: got %h exp %h", obs1, x); else n_pass++;
        // Load something, then assert reset mid-cycle
        en = 1; in_pc = 32'h3010; in_instr = 32'h2408_0001; in_a3 = 5'd8; in_grf_write = 1; in_tnew = 4'd2;
        in_payload = 128'hAA;
        e = model(rst_exp); sb1_q.push_back(e);
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL reset_preload: got %h exp %h", obs1, x); else n_pass++;
        #2;
        reset = 1;
        sb1_q.push_back(rst_exp); sb2_q.push_back(rst_exp);
        #1;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL reset_async1: got %h exp %h", obs1, x); else n_pass++;
        x = sb2_q.pop_front(); n_total++;
        if (obs2 !== x) $display("FAIL reset_async2: got %h exp %h", obs2, x); else n_pass++;
        sb1_q.push_back(rst_exp);
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL reset_stays: got %h exp %h", obs1, x); else n_pass++;
        reset = 0; drive_idle();
        cur_exp = rst_exp;
    endtask

    task automatic test_advance_tnew;
        obs_t x;
        drive_idle();
        en = 1; in_pc = 32'h3004; in_instr = 32'h0123_4567; in_tnew = 4'd2; in_grf_write = 1; in_a3 = 5'd5;
        in_payload = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        e = '0; e.valid = 1; e.pc = 32'h3004; e.instr = 32'h0123_4567; e.tnew = 4'd1;
        e.grf_write = 1; e.a3 = 5'd5; e.payload = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        sb1_q.push_back(e); cur_exp = e;
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL advance_tnew2: got %h exp %h", obs1, x); else n_pass++;
        in_tnew = 4'd0; in_pc = 32'h3008;
        e.tnew = 4'd0; e.pc = 32'h3008;
        sb1_q.push_back(e); cur_exp = e;
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL advance_tnew0_nowrap: got %h exp %h", obs1, x); else n_pass++;
    endtask

    task automatic test_hold;
        obs_t x;
        obs_t e2;
        drive_idle();
        en = 1; in_pc = 32'h300C; in_instr = 32'h0000_0018; in_tnew = 4'd4; in_grf_write = 1; in_a3 = 5'd3;
        in_payload = 128'hBEEF;
        e = '0; e.valid = 1; e.pc = 32'h300C; e.instr = 32'h0000_0018; e.tnew = 4'd3;
        e.grf_write = 1; e.a3 = 5'd3; e.payload = 128'hBEEF;
        e2 = e;
        sb1_q.push_back(e); sb2_q.push_back(e2);
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL hold_load1: got %h exp %h", obs1, x); else n_pass++;
        x = sb2_q.pop_front(); n_total++;
        if (obs2 !== x) $display("FAIL hold_load2: got %h exp %h", obs2, x); else n_pass++;
        // Stall for four edges with changing inputs that must be ignored
        for (int i = 0; i < 4; i++) begin
            en = 0; in_pc = $urandom(); in_instr = $urandom(); in_tnew = 4'($urandom_range(0, 15));
            in_a3 = 5'($urandom_range(0, 31)); in_payload = {$urandom(), $urandom(), $urandom(), $urandom()};
            e.tnew = (i == 0) ? 4'd2 : (i == 1) ? 4'd1 : 4'd0;
            sb1_q.push_back(e); sb2_q.push_back(e2);
            tick;
            x = sb1_q.pop_front(); n_total++;
            if (obs1 !== x) $display("FAIL hold_dec cycle%0d: got %h exp %h", i, obs1, x); else n_pass++;
            x = sb2_q.pop_front(); n_total++;
            if (obs2 !== x) $display("FAIL hold_nodec cycle%0d: got %h exp %h", i, obs2, x); else n_pass++;
        end
        cur_exp = e;
    endtask

    task automatic test_flush;
        obs_t x;
        drive_idle();
        flush = 1; en = 0; in_pc = 32'h3020; in_bd = 1; in_instr = 32'hFFFF_FFFF;
        in_grf_write = 1; in_a3 = 5'd9; in_tnew = 4'd3; in_exc_vld = 1; in_exc = 5'd10;
        in_payload = 128'h55;
        e = '0; e.pc = 32'h3020; e.bd = 1;
        sb1_q.push_back(e); cur_exp = e;
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL flush_en0: got %h exp %h", obs1, x); else n_pass++;
        en = 1; in_pc = 32'h3024; in_bd = 0;
        e = '0; e.pc = 32'h3024;
        sb1_q.push_back(e); cur_exp = e;
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL flush_en1: got %h exp %h", obs1, x); else n_pass++;
    endtask

    task automatic test_exc_merge;
        obs_t x;
        drive_idle();
        en = 1; in_pc = 32'h3030; in_instr = 32'h8C00_0001; in_grf_write = 1; in_a3 = 5'd7; in_tnew = 4'd1;
        in_exc_vld = 1; in_exc = 5'd4; local_exc_vld = 1; local_exc = 5'd12;
        e = '0; e.valid = 1; e.pc = 32'h3030; e.instr = 32'h8C00_0001; e.a3 = 5'd7;
        e.exc_vld = 1; e.exc = 5'd4; e.grf_write = 0; e.tnew = 4'd0;
        sb1_q.push_back(e); cur_exp = e;
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL exc_upstream_wins: got %h exp %h", obs1, x); else n_pass++;
        in_exc_vld = 0;
        e.exc = 5'd12;
        sb1_q.push_back(e); cur_exp = e;
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL exc_local_only: got %h exp %h", obs1, x); else n_pass++;
        local_exc_vld = 0;
        e.exc_vld = 0; e.exc = 5'd12; e.grf_write = 1;
        sb1_q.push_back(e); cur_exp = e;
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL exc_none_writes: got %h exp %h", obs1, x); else n_pass++;
    endtask

    task automatic test_req;
        obs_t x;
        drive_idle();
        req = 1; flush = 1; en = 1; local_exc_vld = 1; local_exc = 5'd12;
        in_pc = 32'h3040; in_instr = 32'h1234_5678; in_grf_write = 1; in_a3 = 5'd2; in_tnew = 4'd3;
        in_bd = 1; in_payload = 128'h77;
        e = '0; e.pc = 32'h0000_4180;
        sb1_q.push_back(e); cur_exp = e;
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL req_redirect: got %h exp %h", obs1, x); else n_pass++;
        req = 0; flush = 0; en = 0;
        sb1_q.push_back(e);
        tick;
        x = sb1_q.pop_front(); n_total++;
        if (obs1 !== x) $display("FAIL req_then_hold: got %h exp %h", obs1, x); else n_pass++;
    endtask

    task automatic test_back_to_back;
        obs_t x;
        for (int i = 0; i < 24; i++) begin
            req = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 5) == 0);
            en = ($urandom_range(0, 3) != 0);
            in_pc = $urandom(); in_instr = $urandom(); in_bd = 1'($urandom_range(0, 1));
            in_exc_vld = ($urandom_range(0, 4) == 0); in_exc = 5'($urandom_range(0, 31));
            local_exc_vld = ($urandom_range(0, 4) == 0); local_exc = 5'($urandom_range(0, 31));
            in_grf_write = 1'($urandom_range(0, 1)); in_a3 = 5'($urandom_range(0, 31));
            in_tnew = 4'($urandom_range(0, 15));
            in_payload = {$urandom(), $urandom(), $urandom(), $urandom()};
            e = model(cur_exp);
            sb1_q.push_back(e); cur_exp = e;
            tick;
            x = sb1_q.pop_front(); n_total++;
            if (obs1 !== x) $display("FAIL b2b cycle%0d: got %h exp %h", i, obs1, x); else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_exp = '0;
        rst_exp.pc = 32'h0000_3000;
        cur_exp = rst_exp;
        drive_idle();
        reset = 1;
        test_reset();
        test_advance_tnew();
        test_hold();
        test_flush();
        test_exc_merge();
        test_req();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
